// File: rtl/pio_multi_pkg.sv
// Shared definitions for the multi-channel Avalon-MM PIO: register indices,
// edge-capture modes and the address-width helper.
package pio_multi_pkg;

    // Register index within a channel (low two address bits)
    localparam logic [1:0] REG_DATA = 2'd0;
    localparam logic [1:0] REG_DIR  = 2'd1;
    localparam logic [1:0] REG_MASK = 2'd2;
    localparam logic [1:0] REG_EDGE = 2'd3;

    typedef enum logic [1:0] {
        EDGE_RISE = 2'd0,
        EDGE_FALL = 2'd1,
        EDGE_ANY  = 2'd2
    } edge_mode_e;

    // Channel field is at least one bit wide, so the address is at least 3 bits
    function automatic int addr_w(input int num_ch);
        int ch_bits;
        ch_bits = (num_ch > 1) ? $clog2(num_ch) : 1;
        return ch_bits + 2;
    endfunction

endpackage

// File: rtl/pio_in_filter.sv
// Per-channel input conditioning: 2-flop synchroniser, optional debounce
// (PIO_DEBOUNCE_EN) and edge detection against the previous filtered value.
module pio_in_filter
    import pio_multi_pkg::*;
#(
    parameter int DATA_W    = 16,
    parameter int EDGE_MODE = 0,
    parameter int DEB_CYC   = 1000
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic [DATA_W-1:0] pin,
    output logic [DATA_W-1:0] filtered,
    output logic [DATA_W-1:0] edge_pulse
);

    localparam edge_mode_e MODE = edge_mode_e'(2'(EDGE_MODE));

    logic [DATA_W-1:0] sync_meta;
    logic [DATA_W-1:0] sync_q;
    logic [DATA_W-1:0] prev_q;

    // Two-stage synchroniser for the asynchronous pins
    // NOTE: non-blocking assignments make both stages sample the old values at the same edge, forming a real 2-flop chain.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync_meta <= '0;
            sync_q    <= '0;
        end else begin
            sync_meta <= pin;
            sync_q    <= sync_meta;
        end
    end

`ifdef PIO_DEBOUNCE_EN
    localparam int CNT_W = $clog2(DEB_CYC + 1);

    logic [DATA_W-1:0] cand_q;
    logic [DATA_W-1:0] filt_q;
    logic [CNT_W-1:0]  cnt_q;

    // Debounce: any change restarts the stability count; the candidate is
    // promoted once it has been sampled DEB_CYC times in a row
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cand_q <= '0;
            filt_q <= '0;
            cnt_q  <= '0;
        end else if (sync_q != cand_q) begin
            cand_q <= sync_q;
            cnt_q  <= CNT_W'(1);
        end else if (cnt_q != CNT_W'(DEB_CYC)) begin
            cnt_q <= cnt_q + CNT_W'(1);
            if (cnt_q == CNT_W'(DEB_CYC - 1)) begin
                filt_q <= cand_q;
            end
        end
    end

    assign filtered = filt_q;
`else
    assign filtered = sync_q;
`endif

    // Previous filtered value keeps tracking regardless of direction
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            prev_q <= '0;
        end else begin
            prev_q <= filtered;
        end
    end

    // Edge pulse selection by capture mode
    // NOTE: assigning a default before the case keeps this purely combinational (no latch).
    always_comb begin
        edge_pulse = filtered & ~prev_q;
        case (MODE)
            EDGE_FALL: edge_pulse = ~filtered & prev_q;
            EDGE_ANY:  edge_pulse = filtered ^ prev_q;
            default:   edge_pulse = filtered & ~prev_q;
        endcase
    end

endmodule

// File: rtl/avalon_pio_multi.sv
// Multi-channel Avalon-MM PIO slave: per channel DATA, DIRECTION, IRQ_MASK and
// EDGE_CAP registers, read latency 1, registered level IRQ.
// Optional input debounce is enabled by defining PIO_DEBOUNCE_EN.
module avalon_pio_multi
    import pio_multi_pkg::*;
#(
    parameter int NUM_CH    = 4,
    parameter int DATA_W    = 16,
    parameter int EDGE_MODE = 0,
    parameter int DEB_CYC   = 1000,
    parameter int ADDR_W    = addr_w(NUM_CH)
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic [ADDR_W-1:0]        avs_address,
    input  logic                     avs_read,
    input  logic                     avs_write,
    input  logic [31:0]              avs_writedata,
    output logic [31:0]              avs_readdata,
    output logic                     irq,
    input  logic [NUM_CH*DATA_W-1:0] pio_in,
    output logic [NUM_CH*DATA_W-1:0] pio_out,
    output logic [NUM_CH*DATA_W-1:0] pio_oe
);

    localparam int CH_W = ADDR_W - 2;

    logic [CH_W-1:0]          ch_sel;
    logic [1:0]               reg_sel;
    logic [DATA_W-1:0]        wdata;
    logic [NUM_CH*DATA_W-1:0] data_view;
    logic [NUM_CH*DATA_W-1:0] mask_flat;
    logic [NUM_CH*DATA_W-1:0] cap_flat;
    logic [NUM_CH-1:0]        irq_src;
    logic [DATA_W-1:0]        rd_val;
    logic                     unused_wdata;

    assign ch_sel       = avs_address[ADDR_W-1:2];
    assign reg_sel      = avs_address[1:0];
    assign wdata        = avs_writedata[DATA_W-1:0];
    assign unused_wdata = ^avs_writedata;

    // Only existing channels get a register file, so writes to channel
    // indices >= NUM_CH match nothing and are dropped
    for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
        logic [DATA_W-1:0] out_q;
        logic [DATA_W-1:0] dir_q;
        logic [DATA_W-1:0] mask_q;
        logic [DATA_W-1:0] cap_q;
        logic [DATA_W-1:0] filt;
        logic [DATA_W-1:0] edge_p;
        logic [DATA_W-1:0] w1c;
        logic              wr_hit;

        pio_in_filter #(
            .DATA_W    (DATA_W),
            .EDGE_MODE (EDGE_MODE),
            .DEB_CYC   (DEB_CYC)
        ) u_filter (
            .clk        (clk),
            .reset_n    (reset_n),
            .pin        (pio_in[c*DATA_W +: DATA_W]),
            .filtered   (filt),
            .edge_pulse (edge_p)
        );

        assign wr_hit = avs_write && (ch_sel == CH_W'(c));
        assign w1c    = (wr_hit && reg_sel == REG_EDGE) ? wdata : '0;

        // Channel register file; a new edge overrides a same-cycle clear
        // NOTE: the register file is a handful of flops, so every bit is reset rather than left undefined like a RAM.
        always_ff @(posedge clk or negedge reset_n) begin
            if (!reset_n) begin
                out_q  <= '0;
                dir_q  <= '0;
                mask_q <= '0;
                cap_q  <= '0;
            end else begin
                if (wr_hit && reg_sel == REG_DATA) out_q  <= wdata;
                if (wr_hit && reg_sel == REG_DIR)  dir_q  <= wdata;
                if (wr_hit && reg_sel == REG_MASK) mask_q <= wdata;
                cap_q <= (cap_q & ~w1c) | (edge_p & ~dir_q);
            end
        end

        assign pio_out[c*DATA_W +: DATA_W]   = out_q;
        assign pio_oe[c*DATA_W +: DATA_W]    = dir_q;
        assign data_view[c*DATA_W +: DATA_W] = (out_q & dir_q) | (filt & ~dir_q);
        assign mask_flat[c*DATA_W +: DATA_W] = mask_q;
        assign cap_flat[c*DATA_W +: DATA_W]  = cap_q;
        assign irq_src[c]                    = |(cap_q & mask_q);
    end

    // Readback mux; unmatched channel indices read as zero
    always_comb begin
        rd_val = '0;
        for (int c = 0; c < NUM_CH; c++) begin
            if (ch_sel == CH_W'(c)) begin
                case (reg_sel)
                    REG_DATA: rd_val = data_view[c*DATA_W +: DATA_W];
                    REG_DIR:  rd_val = pio_oe[c*DATA_W +: DATA_W];
                    REG_MASK: rd_val = mask_flat[c*DATA_W +: DATA_W];
                    default:  rd_val = cap_flat[c*DATA_W +: DATA_W];
                endcase
            end
        end
    end

    // Read data register (latency 1, holds between reads) and level IRQ
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            avs_readdata <= '0;
            irq          <= 1'b0;
        end else begin
            if (avs_read) begin
                avs_readdata <= 32'(rd_val);
            end
            irq <= |irq_src;
        end
    end

endmodule

// File: tb/tb_avalon_pio_multi.sv
// Directed self-checking bench for avalon_pio_multi (NUM_CH=3, DATA_W=16,
// rising-edge capture). Debounce steps run only when PIO_DEBOUNCE_EN is defined.
module tb_avalon_pio_multi;

`ifdef PIO_DEBOUNCE_EN
    localparam int DEB_LAT = 8;
`else
    localparam int DEB_LAT = 0;
`endif

    logic        clk;
    logic        reset_n;
    logic [3:0]  avs_address;
    logic        avs_read;
    logic        avs_write;
    logic [31:0] avs_writedata;
    logic [31:0] avs_readdata;
    logic        irq;
    logic [47:0] pio_in;
    logic [47:0] pio_out;
    logic [47:0] pio_oe;
    logic [31:0] d;

    int checks = 0;
    int errors = 0;

    avalon_pio_multi #(
        .NUM_CH    (3),
        .DATA_W    (16),
        .EDGE_MODE (0),
        .DEB_CYC   (8)
    ) dut (
        .clk           (clk),
        .reset_n       (reset_n),
        .avs_address   (avs_address),
        .avs_read      (avs_read),
        .avs_write     (avs_write),
        .avs_writedata (avs_writedata),
        .avs_readdata  (avs_readdata),
        .irq           (irq),
        .pio_in        (pio_in),
        .pio_out       (pio_out),
        .pio_oe        (pio_oe)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic wr(input logic [3:0] a, input logic [31:0] v);
        @(negedge clk);
        avs_address   = a;
        avs_writedata = v;
        avs_write     = 1'b1;
        @(negedge clk);
        avs_write     = 1'b0;
    endtask

    task automatic rd(input logic [3:0] a, output logic [31:0] v);
        @(negedge clk);
        avs_address = a;
        avs_read    = 1'b1;
        @(negedge clk);
        avs_read    = 1'b0;
        v           = avs_readdata;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog timeout");
        $fatal(1, "simulation did not finish");
    end

    initial begin
        reset_n       = 1'b0;
        avs_address   = '0;
        avs_read      = 1'b0;
        avs_write     = 1'b0;
        avs_writedata = '0;
        pio_in        = '0;

        // 1: write of DATA=0xBEEF issued while reset is held
        @(negedge clk);
        avs_address   = 4'h0;
        avs_writedata = 32'h0000_BEEF;
        avs_write     = 1'b1;
        @(negedge clk);
        @(negedge clk);
        avs_write = 1'b0;
        reset_n   = 1'b1;
        check("reset_pio_out", pio_out, 48'h0);
        check("reset_pio_oe", pio_oe, 48'h0);
        check("reset_irq", irq, 1'b0);
        check("reset_readdata", avs_readdata, 32'h0);
        for (int c = 0; c < 3; c++) begin
            for (int r = 0; r < 4; r++) begin
                rd(4'(c * 4 + r), d);
                check($sformatf("reset_reg_c%0d_r%0d", c, r), d, 32'h0);
            end
        end

        // 2: ch2 output, upper write bits ignored
        wr(4'h9, 32'h0000_FFFF);
        wr(4'h8, 32'hDEAD_1234);
        check("ch2_pio_out", pio_out[47:32], 16'h1234);
        check("ch2_pio_oe", pio_oe[47:32], 16'hFFFF);
        check("ch01_pio_out_untouched", pio_out[31:0], 32'h0);
        rd(4'h8, d);
        check("ch2_data_read", d, 32'h0000_1234);
        rd(4'h9, d);
        check("ch2_dir_read", d, 32'h0000_FFFF);

        // 3: rising edge on ch0 bit0 with mask, exact latency
        wr(4'h2, 32'h1);
        @(negedge clk);
        pio_in[0] = 1'b1;
        repeat (2 + DEB_LAT) @(negedge clk);
        check("irq_before_cap", irq, 1'b0);
        avs_address = 4'h3;
        avs_read    = 1'b1;
        @(negedge clk);
        check("cap_not_early", avs_readdata, 32'h0);
        check("irq_not_early", irq, 1'b0);
        @(negedge clk);
        avs_read = 1'b0;
        check("cap_at_3", avs_readdata, 32'h1);
        check("irq_at_4", irq, 1'b1);
        wr(4'h3, 32'h1);
        check("irq_one_cycle_after_w1c", irq, 1'b1);
        @(negedge clk);
        check("irq_cleared", irq, 1'b0);
        rd(4'h3, d);
        check("cap_cleared", d, 32'h0);
        pio_in[0] = 1'b0;
        repeat (5 + DEB_LAT) @(negedge clk);
        rd(4'h3, d);
        check("no_fall_capture", d, 32'h0);
        check("irq_after_fall", irq, 1'b0);

        // 4: edge on ch1 bit3 colliding with W1C of the same bit
        pio_in[19] = 1'b1;
        repeat (5 + DEB_LAT) @(negedge clk);
        rd(4'h7, d);
        check("ch1_rise", d, 32'h8);
        check("ch1_unmasked_no_irq", irq, 1'b0);
        pio_in[19] = 1'b0;
        repeat (5 + DEB_LAT) @(negedge clk);
        @(negedge clk);
        pio_in[19] = 1'b1;
        repeat (2 + DEB_LAT) @(negedge clk);
        avs_address   = 4'h7;
        avs_writedata = 32'h8;
        avs_write     = 1'b1;
        @(negedge clk);
        avs_write = 1'b0;
        rd(4'h7, d);
        check("collision_set_wins", d, 32'h8);
        check("collision_irq_masked", irq, 1'b0);
        wr(4'h6, 32'h8);
        check("irq_mask_lag", irq, 1'b0);
        @(negedge clk);
        check("irq_ch1_mask", irq, 1'b1);
        wr(4'h7, 32'h8);
        @(negedge clk);
        check("irq_ch1_cleared", irq, 1'b0);

        // Mixed direction on ch0: outputs read back pio_out, inputs read pins
        wr(4'h1, 32'h2);
        wr(4'h0, 32'h3);
        pio_in[1] = 1'b1;
        pio_in[2] = 1'b1;
        repeat (5 + DEB_LAT) @(negedge clk);
        rd(4'h0, d);
        check("data_mix", d, 32'h6);
        rd(4'h3, d);
        check("cap_only_inputs", d, 32'h4);
        check("ch0_pio_out", pio_out[15:0], 16'h3);
        check("ch0_pio_oe", pio_oe[15:0], 16'h2);
        check("irq_bit2_unmasked", irq, 1'b0);

        // 5: channel 3 does not exist
        wr(4'hC, 32'hFFFF);
        wr(4'hD, 32'hFFFF);
        wr(4'hE, 32'hFFFF);
        wr(4'hF, 32'hFFFF);
        check("oor_pio_out", pio_out, 48'h1234_0000_0003);
        check("oor_pio_oe", pio_oe, 48'hFFFF_0000_0002);
        check("oor_irq", irq, 1'b0);
        rd(4'hC, d);
        check("oor_read_data", d, 32'h0);
        rd(4'hF, d);
        check("oor_read_edge", d, 32'h0);

        // Read and write of the same register in one cycle
        @(negedge clk);
        avs_address   = 4'h8;
        avs_writedata = 32'h5555;
        avs_write     = 1'b1;
        avs_read      = 1'b1;
        @(negedge clk);
        avs_write = 1'b0;
        avs_read  = 1'b0;
        check("rw_pre_write_data", avs_readdata, 32'h1234);
        check("rw_write_applied", pio_out[47:32], 16'h5555);
        repeat (3) @(negedge clk);
        check("readdata_hold", avs_readdata, 32'h1234);

`ifdef PIO_DEBOUNCE_EN
        // 6: debounce on ch0 bit4, DEB_CYC=8
        wr(4'h3, 32'hFFFF);
        @(negedge clk);
        pio_in[4] = 1'b1;
        repeat (5) @(negedge clk);
        pio_in[4] = 1'b0;
        repeat (20) @(negedge clk);
        rd(4'h3, d);
        check("glitch_rejected", d, 32'h0);
        @(negedge clk);
        pio_in[4] = 1'b1;
        repeat (10) @(negedge clk);
        avs_address = 4'h3;
        avs_read    = 1'b1;
        @(negedge clk);
        check("deb_not_early", avs_readdata, 32'h0);
        @(negedge clk);
        avs_read  = 1'b0;
        pio_in[4] = 1'b0;
        check("deb_cap_at_11", avs_readdata, 32'h10);
`endif

        // Asynchronous reset in the middle of operation
        @(negedge clk);
        #2 reset_n = 1'b0;
        #1;
        check("async_rst_pio_out", pio_out, 48'h0);
        check("async_rst_pio_oe", pio_oe, 48'h0);
        check("async_rst_irq", irq, 1'b0);
        check("async_rst_readdata", avs_readdata, 32'h0);
        @(negedge clk);
        reset_n = 1'b1;
        rd(4'h9, d);
        check("dir_after_reset", d, 32'h0);
        rd(4'h8, d);
        check("data_after_reset", d, 32'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
